ippcrc_crc32_stream: RTL and testbench

Streaming, parametrised CRC-32 engine for packet data on a DW-bit bus with byte-granular packet end.
- Accumulates the CRC across words between sop and eop, then delivers the final CRC one cycle after eop.
- Optional residue-check mode flags whether a received packet, including its appended CRC, is intact.
- Sits beside the framers and deframers in ippcrc and replaces fixed-width combinational CRC slices with one registered engine.

---
 rtl/ippcrc_crc32_stream.sv | 122 ++++++++++++
 tb/tb_ippcrc_crc32_stream.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ippcrc_crc32_stream.sv
// Streaming MSB-first CRC-32 engine over a DW-bit bus with byte-granular packet end.
// Define IPPCRC_CHECK_EN to enable the residue check that drives crc_ok.
module ippcrc_crc32_stream #(
  parameter int          DW      = 64,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
`ifdef IPPCRC_CHECK_EN
  parameter logic [31:0] RESIDUE = 32'hC704DD7B,
`endif
  parameter int          NBW     = (DW / 8 > 1) ? $clog2(DW / 8) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vld,
  input  logic           sop,
  input  logic           eop,
  input  logic [NBW-1:0] nbyte,
  input  logic [DW-1:0]  dat,
  output logic [31:0]    crc_o,
  output logic           crc_vld,
  output logic           crc_ok,
  output logic           err
);

  localparam int NL = DW / 8;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_n;
  logic [31:0]            acc, acc_n;
  logic [31:0]            base_p0;
  logic [NL-1:0][31:0]    chain_p0;
  logic [31:0]            fin_p0;
  logic                   vld_p0;
  logic                   err_p0;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = {r[30:0], 1'b0} ^ (POLY & {32{r[31] ^ b[i]}});
    return r;
  endfunction

  // Entry k holds the state after lanes 0..k, so any lane count is a simple pick.
  function automatic logic [NL-1:0][31:0] lane_chain(input logic [31:0] c,
                                                     input logic [DW-1:0] d);
    logic [NL-1:0][31:0] r;
    logic [31:0]         t;
    t = c;
    for (int k = 0; k < NL; k++) begin
      t    = crc_byte(t, d[8*k +: 8]);
      r[k] = t;
    end
    return r;
  endfunction

  // Stage p0: combinational lane update and packet control
  always_comb begin
    base_p0  = sop ? INIT : acc;
    chain_p0 = lane_chain(base_p0, dat);
    fin_p0   = chain_p0[NL-1];
    for (int k = 0; k < NL - 1; k++)
      if (nbyte == NBW'(k + 1)) fin_p0 = chain_p0[k];
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    vld_p0  = 1'b0;
    err_p0  = 1'b0;
    if (vld) begin
      if (sop) begin
        err_p0 = (state == ACTIVE);
        if (eop) begin
          vld_p0  = 1'b1;
          acc_n   = INIT;
          state_n = IDLE;
        end else begin
          acc_n   = chain_p0[NL-1];
          state_n = ACTIVE;
        end
      end else if (state == IDLE) begin
        err_p0 = 1'b1;
      end else if (eop) begin
        vld_p0  = 1'b1;
        acc_n   = INIT;
        state_n = IDLE;
      end else begin
        acc_n = chain_p0[NL-1];
      end
    end
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= INIT;
      crc_o   <= '0;
      crc_vld <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      crc_vld <= vld_p0;
      err     <= err_p0;
      if (vld_p0) crc_o <= fin_p0 ^ XOROUT;
    end
  end

`ifdef IPPCRC_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         crc_ok <= 1'b0;
    else if (vld_p0) crc_ok <= (fin_p0 == RESIDUE);
  end
`else
  assign crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_ippcrc_crc32_stream.sv
// Directed bench for ippcrc_crc32_stream: a 64-bit and an 8-bit instance checked
// against hand-computed CRC-32/BZIP2 values.
module tb_ippcrc_crc32_stream;

  localparam logic [31:0] CHK  = 32'hFC891918;
  localparam logic [31:0] RESO = 32'h38FB2284;
  localparam logic [63:0] W1   = 64'h3837363534333231;
  localparam logic [63:0] W2   = 64'h0000000000000039;
  localparam logic [63:0] WC   = 64'h000000181989FC39;
  localparam logic [63:0] WCB  = 64'h000000181989FC38;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        vld64 = 0, sop64 = 0, eop64 = 0;
  logic [2:0]  nb64 = '0;
  logic [63:0] dat64 = '0;
  logic [31:0] crc64;
  logic        cv64, ok64, err64;

  logic        vld8 = 0, sop8 = 0, eop8 = 0;
  logic [0:0]  nb8 = '0;
  logic [7:0]  dat8 = '0;
  logic [31:0] crc8;
  logic        cv8, ok8, err8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ippcrc_crc32_stream #(.DW(64)) dut64 (
    .clk(clk), .rst(rst), .vld(vld64), .sop(sop64), .eop(eop64), .nbyte(nb64),
    .dat(dat64), .crc_o(crc64), .crc_vld(cv64), .crc_ok(ok64), .err(err64));

  ippcrc_crc32_stream #(.DW(8)) dut8 (
    .clk(clk), .rst(rst), .vld(vld8), .sop(sop8), .eop(eop8), .nbyte(nb8),
    .dat(dat8), .crc_o(crc8), .crc_vld(cv8), .crc_ok(ok8), .err(err8));

  task automatic step64(input logic v, input logic s, input logic e,
                        input logic [2:0] nb, input logic [63:0] d);
    vld64 = v; sop64 = s; eop64 = e; nb64 = nb; dat64 = d;
    @(posedge clk); #1;
  endtask

  task automatic step8(input logic v, input logic s, input logic e, input logic [7:0] d);
    vld8 = v; sop8 = s; eop8 = e; nb8 = '0; dat8 = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (crc64 !== 32'h0) begin fails++; $display("FAIL reset_crc64: got %h want 0", crc64); end
    tests++; if (cv64 !== 1'b0) begin fails++; $display("FAIL reset_vld64: got %b want 0", cv64); end
    tests++; if (ok64 !== 1'b0) begin fails++; $display("FAIL reset_ok64: got %b want 0", ok64); end
    tests++; if (err64 !== 1'b0) begin fails++; $display("FAIL reset_err64: got %b want 0", err64); end
    tests++; if ({crc8, cv8, ok8, err8} !== 35'h0) begin fails++; $display("FAIL reset_dut8: got %h want 0", {crc8, cv8, ok8, err8}); end
    rst = 1'b0;
    step64(0, 0, 0, 0, 0);
  endtask

  task automatic test_two_word;
    step64(1, 1, 0, 0, W1);
    tests++; if (cv64 !== 1'b0) begin fails++; $display("FAIL tw_early_vld: got %b want 0", cv64); end
    step64(1, 0, 1, 3'd1, W2);
    tests++; if (cv64 !== 1'b1) begin fails++; $display("FAIL tw_vld: got %b want 1", cv64); end
    tests++; if (crc64 !== CHK) begin fails++; $display("FAIL tw_crc: got %h want %h", crc64, CHK); end
    tests++; if (err64 !== 1'b0) begin fails++; $display("FAIL tw_err: got %b want 0", err64); end
    step64(0, 0, 0, 0, 0);
    tests++; if (cv64 !== 1'b0) begin fails++; $display("FAIL tw_pulse: got %b want 0", cv64); end
    tests++; if (crc64 !== CHK) begin fails++; $display("FAIL tw_hold: got %h want %h", crc64, CHK); end
  endtask

  task automatic test_bytes8;
    for (int i = 0; i < 9; i++) step8(1, i == 0, i == 8, 8'h31 + 8'(i));
    tests++; if (cv8 !== 1'b1) begin fails++; $display("FAIL b8_vld: got %b want 1", cv8); end
    tests++; if (crc8 !== CHK) begin fails++; $display("FAIL b8_crc: got %h want %h", crc8, CHK); end
    step8(1, 1, 1, 8'h00);
    tests++; if (crc8 === CHK) begin fails++; $display("FAIL b8_change: got %h want other than %h", crc8, CHK); end
    for (int i = 0; i < 9; i++) begin
      step8(1, i == 0, i == 8, 8'h31 + 8'(i));
      if (i != 8) begin
        step8(0, 1, 1, 8'hA5);
        if (i % 3 == 0) step8(0, 0, 0, 8'h00);
      end
    end
    tests++; if (cv8 !== 1'b1) begin fails++; $display("FAIL b8gap_vld: got %b want 1", cv8); end
    tests++; if (crc8 !== CHK) begin fails++; $display("FAIL b8gap_crc: got %h want %h", crc8, CHK); end
    tests++; if (err8 !== 1'b0) begin fails++; $display("FAIL b8gap_err: got %b want 0", err8); end
    step8(0, 0, 0, 0);
  endtask

  task automatic test_check;
    step64(1, 1, 0, 0, W1);
    step64(1, 0, 1, 3'd5, WC);
    tests++; if (crc64 !== RESO) begin fails++; $display("FAIL chk_crc: got %h want %h", crc64, RESO); end
`ifdef IPPCRC_CHECK_EN
    tests++; if (ok64 !== 1'b1) begin fails++; $display("FAIL chk_ok: got %b want 1", ok64); end
`else
    tests++; if (ok64 !== 1'b0) begin fails++; $display("FAIL chk_tied: got %b want 0", ok64); end
`endif
    step64(1, 1, 0, 0, W1);
    step64(1, 0, 1, 3'd5, WCB);
    tests++; if (ok64 !== 1'b0) begin fails++; $display("FAIL chk_bad_ok: got %b want 0", ok64); end
    tests++; if (crc64 === RESO) begin fails++; $display("FAIL chk_bad_crc: got %h want other than %h", crc64, RESO); end
    step64(0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    step64(1, 1, 0, 0, W1);
    step64(1, 0, 1, 3'd1, W2);
    tests++; if (cv64 !== 1'b1 || crc64 !== CHK) begin fails++; $display("FAIL b2b_a: got vld=%b crc=%h want 1 %h", cv64, crc64, CHK); end
    step64(1, 1, 0, 0, W1);
    tests++; if (cv64 !== 1'b0 || err64 !== 1'b0) begin fails++; $display("FAIL b2b_gap: got vld=%b err=%b want 0 0", cv64, err64); end
    step64(1, 0, 1, 3'd1, W2);
    tests++; if (cv64 !== 1'b1 || crc64 !== CHK) begin fails++; $display("FAIL b2b_b: got vld=%b crc=%h want 1 %h", cv64, crc64, CHK); end
    tests++; if (err64 !== 1'b0) begin fails++; $display("FAIL b2b_err: got %b want 0", err64); end
    step64(0, 0, 0, 0, 0);
  endtask

  task automatic test_errors;
    step64(1, 0, 0, 0, W1);
    tests++; if (err64 !== 1'b1) begin fails++; $display("FAIL err_idle: got %b want 1", err64); end
    tests++; if (cv64 !== 1'b0) begin fails++; $display("FAIL err_idle_vld: got %b want 0", cv64); end
    step64(0, 0, 0, 0, 0);
    tests++; if (err64 !== 1'b0) begin fails++; $display("FAIL err_pulse: got %b want 0", err64); end
    step64(1, 1, 0, 0, 64'hDEADBEEFCAFEF00D);
    step64(1, 1, 0, 0, W1);
    tests++; if (err64 !== 1'b1) begin fails++; $display("FAIL err_trunc: got %b want 1", err64); end
    tests++; if (cv64 !== 1'b0) begin fails++; $display("FAIL err_trunc_vld: got %b want 0", cv64); end
    step64(1, 0, 1, 3'd1, W2);
    tests++; if (crc64 !== CHK || cv64 !== 1'b1) begin fails++; $display("FAIL err_restart: got vld=%b crc=%h want 1 %h", cv64, crc64, CHK); end
    tests++; if (err64 !== 1'b0) begin fails++; $display("FAIL err_restart_err: got %b want 0", err64); end
    step64(0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset;
    step64(1, 1, 0, 0, W1);
    vld64 = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests++; if (crc64 !== 32'h0) begin fails++; $display("FAIL arst_crc: got %h want 0", crc64); end
    #1 rst = 1'b0;
    step64(1, 0, 1, 3'd1, W2);
    tests++; if (err64 !== 1'b1 || cv64 !== 1'b0) begin fails++; $display("FAIL arst_discard: got err=%b vld=%b want 1 0", err64, cv64); end
    step64(1, 1, 0, 0, W1);
    step64(1, 0, 1, 3'd1, W2);
    tests++; if (crc64 !== CHK || cv64 !== 1'b1) begin fails++; $display("FAIL arst_fresh: got vld=%b crc=%h want 1 %h", cv64, crc64, CHK); end
    step64(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_bytes8();
    test_check();
    test_back_to_back();
    test_errors();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
